alu_instr_sequencer: RTL and testbench

Parametrised control-step sequencer for the CPU datapath. It replaces hand-driven control waveforms with a real state machine. On `start` it fetches one instruction and decodes it, then emits the one-hot register select/enable strobes that execute it. Covered classes are binary register-register ALU ops, unary ops, and wide (MUL/DIV, HI/LO) ops. It sits between the control unit's run logic and the `datapath` control inputs.

---
 rtl/alu_instr_sequencer.sv | 94 +++++++++
 tb/tb_alu_instr_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: fetch/decode/execute control-step FSM driving the datapath strobes
module alu_instr_sequencer #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int OPCODE_W = 5
) (
   input  logic                clock,
   input  logic                clear,
   input  logic                start,
   input  logic [DATA_W-1:0]   ir,
   output logic                busy,
   output logic                done,
   output logic                illegal,
   output logic                PCout,
   output logic                PCin,
   output logic                IncPC,
   output logic                MARin,
   output logic                Read,
   output logic                MDRin,
   output logic                MDRout,
   output logic                IRin,
   output logic                Yin,
   output logic                Zin,
   output logic                Zlowout,
   output logic                Zhighout,
   output logic                LOin,
   output logic                HIin,
   output logic [NUM_REGS-1:0] Rout,
   output logic [NUM_REGS-1:0] Rin,
   output logic [OPCODE_W-1:0] alu_op
);
   localparam int RSEL_W = $clog2(NUM_REGS);
   localparam logic [2:0] IDLE = 3'd0, F0 = 3'd1, F1 = 3'd2, F2 = 3'd3,
                          OPA = 3'd4, OPB = 3'd5, WRLO = 3'd6, WRHI = 3'd7;
   logic [2:0] state, next_state;
   logic [OPCODE_W-1:0] op;
   logic [RSEL_W-1:0] ra, rb, rc;
   logic [NUM_REGS-1:0] sel_a, sel_b, sel_c;
   logic is_bin, is_wide, is_un, legal, unused_ir;
   assign op        = ir[DATA_W-1 -: OPCODE_W];
   assign ra        = ir[DATA_W-OPCODE_W-1 -: RSEL_W];
   assign rb        = ir[DATA_W-OPCODE_W-RSEL_W-1 -: RSEL_W];
   assign rc        = ir[DATA_W-OPCODE_W-2*RSEL_W-1 -: RSEL_W];
   assign unused_ir = ^ir[DATA_W-OPCODE_W-3*RSEL_W-1:0];
   assign is_bin    = op >= OPCODE_W'(3) && op <= OPCODE_W'(10);
   assign is_wide   = op == OPCODE_W'(15) || op == OPCODE_W'(16);
   assign is_un     = op == OPCODE_W'(17) || op == OPCODE_W'(18);
   assign legal     = is_bin || is_wide || is_un;
   assign sel_a     = NUM_REGS'(1) << ra;
   assign sel_b     = NUM_REGS'(1) << rb;
   assign sel_c     = NUM_REGS'(1) << rc;
   // next step: fetch runs unconditionally, OPA picks the execute path, final steps may chain
   always_comb begin
      next_state = IDLE;
      case (state)
         IDLE: next_state = start ? F0 : IDLE;
         F0:   next_state = F1;
         F1:   next_state = F2;
         F2:   next_state = OPA;
         OPA:  next_state = !legal ? IDLE : is_un ? WRLO : OPB;
         OPB:  next_state = WRLO;
         WRLO: next_state = is_wide ? WRHI : start ? F0 : IDLE;
         WRHI: next_state = start ? F0 : IDLE;
      endcase
   end
   // state register, cleared asynchronously so every strobe drops without waiting for a clock
   always_ff @(posedge clock or posedge clear) begin
      if (clear) state <= IDLE;
      else       state <= next_state;
   end
   assign busy     = state != IDLE;
   assign PCout    = state == F0;
   assign MARin    = state == F0;
   assign IncPC    = state == F0;
   assign PCin     = state == F1;
   assign Read     = state == F1;
   assign MDRin    = state == F1;
   assign MDRout   = state == F2;
   assign IRin     = state == F2;
   assign Yin      = state == OPA && (is_bin || is_wide);
   assign Zin      = state == F0 || state == OPB || (state == OPA && is_un);
   assign Zlowout  = state == F1 || state == WRLO;
   assign Zhighout = state == WRHI;
   assign HIin     = state == WRHI;
   assign LOin     = state == WRLO && is_wide;
   assign illegal  = state == OPA && !legal;
   assign done     = (state == WRLO && !is_wide) || state == WRHI;
   assign alu_op   = (state == OPB || (state == OPA && is_un)) ? op : '0;
   assign Rout     = (state == OPA && (is_bin || is_un)) ? sel_b :
                     (state == OPA && is_wide)           ? sel_a :
                     (state == OPB && is_bin)            ? sel_c :
                     (state == OPB)                      ? sel_b : '0;
   assign Rin      = (state == WRLO && !is_wide) ? sel_a : '0;
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: table vectors, hand sequences and random instructions against a step-list model
module tb_alu_instr_sequencer;
   logic clock = 0, clear = 1, start = 0;
   logic [31:0] ir = '0;
   logic busy, done, illegal, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
   logic Yin, Zin, Zlowout, Zhighout, LOin, HIin;
   logic [15:0] Rout, Rin;
   logic [4:0] alu_op;

   alu_instr_sequencer dut (
      .clock(clock), .clear(clear), .start(start), .ir(ir), .busy(busy), .done(done),
      .illegal(illegal), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
      .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
      .Zlowout(Zlowout), .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin),
      .Rout(Rout), .Rin(Rin), .alu_op(alu_op)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic busy, done, illegal;
      logic [13:0] s;
      logic [15:0] rout, rin;
      logic [4:0] alu;
   } out_t;

   typedef struct {
      logic [31:0] ir;
      int cycles;
      logic [15:0] rout_or, rin_or;
      int yin_n, done_n, ill_n;
   } vec_t;

   localparam int M_PCOUT = 1 << 0, M_PCIN = 1 << 1, M_INCPC = 1 << 2, M_MARIN = 1 << 3;
   localparam int M_READ = 1 << 4, M_MDRIN = 1 << 5, M_MDROUT = 1 << 6, M_IRIN = 1 << 7;
   localparam int M_YIN = 1 << 8, M_ZIN = 1 << 9, M_ZLO = 1 << 10, M_ZHI = 1 << 11;
   localparam int M_LOIN = 1 << 12, M_HIIN = 1 << 13;

   out_t obs;
   assign obs = {busy, done, illegal,
                 {HIin, LOin, Zhighout, Zlowout, Zin, Yin, IRin, MDRout, MDRin, Read, MARin, IncPC, PCin, PCout},
                 Rout, Rin, alu_op};

   out_t exp_q[$];
   int n_tests = 0, n_fail = 0;
   int a_cycles, a_yin, a_done, a_ill;
   logic [15:0] a_rout, a_rin;

   function automatic void check(string name, logic [63:0] got, logic [63:0] expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, expv);
      end
   endfunction

   function automatic out_t step(int s, logic [15:0] rout, logic [15:0] rin, logic [4:0] alu, logic dn, logic il);
      out_t o;
      o.busy = 1'b1; o.done = dn; o.illegal = il; o.s = 14'(s);
      o.rout = rout; o.rin = rin; o.alu = alu;
      return o;
   endfunction

   function automatic logic [31:0] enc(int op, int a, int b, int c);
      return (32'(op) << 27) | (32'(a) << 23) | (32'(b) << 19) | (32'(c) << 15);
   endfunction

   // expected per-cycle outputs for one instruction, written as the list of control steps
   function automatic void model(logic [31:0] v);
      logic [4:0] op;
      logic [15:0] a, b, c;
      bit bin, wide, un;
      op = v[31:27];
      a = 16'd1 << v[26:23];
      b = 16'd1 << v[22:19];
      c = 16'd1 << v[18:15];
      bin = op inside {[5'd3:5'd10]};
      wide = op inside {5'd15, 5'd16};
      un = op inside {5'd17, 5'd18};
      exp_q.delete();
      exp_q.push_back(step(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0, 0, 0, 0, 0));
      exp_q.push_back(step(M_ZLO | M_PCIN | M_READ | M_MDRIN, 0, 0, 0, 0, 0));
      exp_q.push_back(step(M_MDROUT | M_IRIN, 0, 0, 0, 0, 0));
      if (bin) begin
         exp_q.push_back(step(M_YIN, b, 0, 0, 0, 0));
         exp_q.push_back(step(M_ZIN, c, 0, op, 0, 0));
         exp_q.push_back(step(M_ZLO, 0, a, 0, 1, 0));
      end else if (wide) begin
         exp_q.push_back(step(M_YIN, a, 0, 0, 0, 0));
         exp_q.push_back(step(M_ZIN, b, 0, op, 0, 0));
         exp_q.push_back(step(M_ZLO | M_LOIN, 0, 0, 0, 0, 0));
         exp_q.push_back(step(M_ZHI | M_HIIN, 0, 0, 0, 1, 0));
      end else if (un) begin
         exp_q.push_back(step(M_ZIN, b, 0, op, 0, 0));
         exp_q.push_back(step(M_ZLO, 0, a, 0, 1, 0));
      end else
         exp_q.push_back(step(0, 0, 0, 0, 0, 1));
   endfunction

   // mode: 0 start low mid-instruction, 1 random, 2 held high
   task automatic run(logic [31:0] v, bit chain, int mode, string tag);
      bit ce;
      int last;
      model(v);
      last = exp_q.size() - 1;
      ce = chain && last > 3;
      a_cycles = 0; a_yin = 0; a_done = 0; a_ill = 0; a_rout = '0; a_rin = '0;
      start = 1'b1;
      for (int i = 0; i <= last; i++) begin
         @(posedge clock);
         if (i == 0) begin
            #1;
            ir = v;
         end
         @(negedge clock);
         check($sformatf("%s_c%0d", tag, i + 1), obs, exp_q[i]);
         check($sformatf("%s_c%0d_rout_rin_overlap", tag, i + 1), Rout & Rin, '0);
         a_cycles += int'(busy); a_yin += int'(Yin); a_done += int'(done); a_ill += int'(illegal);
         a_rout |= Rout; a_rin |= Rin;
         start = i == last ? ce : mode == 2 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (!ce) begin
         @(posedge clock);
         @(negedge clock);
         check($sformatf("%s_idle", tag), obs, '0);
         a_cycles += int'(busy);
      end
   endtask

   vec_t tbl[6];

   initial begin
      tbl[0] = '{32'h28918000, 6, 16'h000C, 16'h0002, 1, 1, 0};
      tbl[1] = '{32'h7A280000, 7, 16'h0030, 16'h0000, 1, 1, 0};
      tbl[2] = '{32'h93380000, 5, 16'h0080, 16'h0040, 0, 1, 0};
      tbl[3] = '{32'hF8000000, 4, 16'h0000, 16'h0000, 0, 0, 1};
      tbl[4] = '{32'h1F870000, 6, 16'h4001, 16'h8000, 1, 1, 0};
      tbl[5] = '{32'h80780000, 7, 16'h8001, 16'h0000, 1, 1, 0};

      repeat (2) @(negedge clock);
      check("reset_outputs", obs, '0);
      clear = 1'b0;
      @(negedge clock);
      check("after_reset_idle", obs, '0);

      foreach (tbl[k]) begin
         run(tbl[k].ir, 1'b0, 0, $sformatf("vec%0d", k));
         check($sformatf("vec%0d_busy_cycles", k), 64'(a_cycles), 64'(tbl[k].cycles));
         check($sformatf("vec%0d_rout_or", k), a_rout, tbl[k].rout_or);
         check($sformatf("vec%0d_rin_or", k), a_rin, tbl[k].rin_or);
         check($sformatf("vec%0d_yin_count", k), 64'(a_yin), 64'(tbl[k].yin_n));
         check($sformatf("vec%0d_done_count", k), 64'(a_done), 64'(tbl[k].done_n));
         check($sformatf("vec%0d_illegal_count", k), 64'(a_ill), 64'(tbl[k].ill_n));
      end

      run(enc(3, 1, 2, 3), 1'b1, 2, "chain_a");
      run(enc(3, 5, 6, 7), 1'b0, 2, "chain_b");

      ir = 32'h28918000;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("rst_f1_read", 64'(Read), 64'(1));
      #2 clear = 1'b1;
      #1 check("rst_async_outputs", obs, '0);
      @(negedge clock);
      check("rst_held_outputs", obs, '0);
      clear = 1'b0;
      @(negedge clock);
      check("rst_release_idle", obs, '0);
      run(32'h28918000, 1'b0, 1, "post_rst");
      check("post_rst_busy_cycles", 64'(a_cycles), 64'(6));

      for (int n = 0; n < 40; n++) begin
         logic [31:0] v;
         v = $urandom();
         v[31:27] = 5'($urandom_range(0, 31));
         run(v, n < 39 ? 1'($urandom_range(0, 1)) : 1'b0, 1, $sformatf("rnd%0d_op%0d", n, v[31:27]));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
